fetch_prefetch_queue: RTL and testbench

//  IF-stage front end for the 5-stage RV64 pipeline. Issues in-order word fetches to instruction memory

---
 rtl/riscv_fetch_pkg.sv | 18 +
 rtl/fetch_queue_fifo.sv | 68 ++++++
 rtl/fetch_prefetch_queue.sv | 117 +++++++++++
 tb/tb_fetch_prefetch_queue.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Contents:
//   FETCH_XLEN / FETCH_ILEN - default PC and instruction widths
//   NOP_INST                - addi x0,x0,0, shown toward IF/ID when no instruction is ready
//   fetch_entry_t           - one queued instruction together with the PC it was fetched from
package riscv_fetch_pkg;

    localparam int FETCH_XLEN = 64;
    localparam int FETCH_ILEN = 32;

    localparam logic [FETCH_ILEN-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_ILEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_fifo.sv
// Circular FIFO holding fetched instructions between instruction memory and IF/ID.
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   clear             - synchronous flush of every entry; takes priority over push/pop
//   push, push_entry  - write one entry at the tail
//   pop               - drop the head entry (caller only pops when count != 0)
//   head              - entry at the head (contents undefined when count == 0)
//   count             - number of valid entries, 0..DEPTH
module fetch_queue_fifo
    import riscv_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  fetch_entry_t     push_entry,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // Explicit wrap so DEPTH does not have to be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Pointer and occupancy bookkeeping. A push and a pop in the same cycle
    // leave the count unchanged, which is what makes push-while-full legal
    // as long as the head leaves in that same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Entry storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_prefetch_queue.sv
// IF-stage prefetch front end: issues in-order word fetches to instruction memory,
// buffers the returned instructions with their PCs and presents one per cycle to IF/ID.
// Ports:
//   clk, reset                         - clock, asynchronous active-high reset
//   imem_req_valid/ready/addr          - fetch request handshake, word-aligned address
//   imem_rsp_valid/data                - in-order responses, latency >= 1
//   stall                              - hazard unit holds the head instruction
//   redirect_valid/redirect_pc         - taken branch / flush, low two target bits ignored
//   inst_valid/inst/inst_pc            - head instruction toward IF/ID (NOP / 0 when empty)
module fetch_prefetch_queue
    import riscv_fetch_pkg::*;
#(
    parameter int              XLEN     = FETCH_XLEN,
    parameter int              ILEN     = FETCH_ILEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    output logic [ILEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  resp_pc;
    logic [XLEN-1:0]  redirect_target;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] count;
    logic             credit_ok;
    logic             req_fire;
    logic             rsp_drop;
    logic             push;
    logic             pop;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    // Every slot is reserved at request time, so a response can never find
    // the queue full. Reset also masks the request so nothing leaves while
    // the memory side is being reset alongside us.
    assign credit_ok       = ({1'b0, count} + {1'b0, outstanding}) < (CNT_W + 1)'(DEPTH);
    assign imem_req_valid  = !reset && !redirect_valid && credit_ok;
    assign imem_req_addr   = fetch_pc;
    assign req_fire        = imem_req_valid && imem_req_ready;
    assign redirect_target = redirect_pc & ~XLEN'(3);

    // Responses belonging to the pre-redirect path are counted off by
    // drop_cnt; a response landing in the redirect cycle itself is stale too.
    assign rsp_drop   = drop_cnt != '0;
    assign push       = imem_rsp_valid && !rsp_drop && !redirect_valid;
    assign pop        = inst_valid && !stall && !redirect_valid;
    assign push_entry = '{pc: resp_pc, inst: imem_rsp_data};

    fetch_queue_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect_valid),
        .push      (push),
        .push_entry(push_entry),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    // Fetch/response PC tracking and in-flight accounting. On a redirect all
    // requests still in flight become stale, so drop_cnt simply takes the
    // post-cycle outstanding value, whatever drop_cnt held before.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (redirect_valid) begin
            fetch_pc    <= redirect_target;
            resp_pc     <= redirect_target;
            outstanding <= outstanding - CNT_W'(imem_rsp_valid);
            drop_cnt    <= outstanding - CNT_W'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
            if (imem_rsp_valid) begin
                if (rsp_drop) begin
                    drop_cnt <= drop_cnt - CNT_W'(1);
                end else begin
                    resp_pc <= resp_pc + XLEN'(4);
                end
            end
        end
    end

    // IF/ID sees a NOP at PC 0 whenever the queue is empty.
    assign inst_valid = count != '0;
    assign inst       = inst_valid ? head.inst : NOP_INST;
    assign inst_pc    = inst_valid ? head.pc : '0;

    // A response with nothing in flight means the memory and this block
    // disagree about the request stream.
    rsp_has_request: assert property (@(posedge clk) disable iff (reset)
        imem_rsp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Self-checking bench for fetch_prefetch_queue: an in-order memory with random
// latency and ready, plus a queue-based reference of the fetch front end.
module tb_fetch_prefetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_pc;

    fetch_prefetch_queue #(
        .DEPTH   (DEPTH),
        .RESET_PC(64'h0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc       (inst_pc)
    );

    always #5 clk = ~clk;

    // One request the memory has accepted; stale ones belong to a flushed path.
    typedef struct {
        logic [63:0] addr;
        int          due;
        bit          stale;
    } req_t;

    req_t        inflight[$];
    logic [63:0] iq[$];
    logic [63:0] fetch_pc_m = '0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          lat_min = 1;
    int          lat_max = 1;

    logic        obs_inst_valid;
    logic [63:0] obs_inst_pc;
    logic        obs_req_valid;
    logic [63:0] obs_req_addr;
    int          obs_count;

    // Memory image: each word's contents derived from its address.
    function automatic logic [31:0] image(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_00F3 ^ {a[15:0], a[31:16]};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // One clock cycle: drive inputs and the memory response at the falling edge,
    // compare against the reference, then advance the reference at the rising edge.
    task automatic applyStimulus(input bit rdy, input bit stl, input bit redir, input logic [63:0] tgt);
        bit   rsp;
        bit   exp_rv;
        bit   do_pop;
        int   lat;
        req_t r;
        @(negedge clk);
        rsp            = (inflight.size() > 0) && (inflight[0].due <= cyc);
        imem_req_ready = rdy;
        stall          = stl;
        redirect_valid = redir;
        redirect_pc    = tgt;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? image(inflight[0].addr) : $urandom;
        #1;
        exp_rv         = !redir && ((iq.size() + inflight.size()) < DEPTH);
        obs_inst_valid = inst_valid;
        obs_inst_pc    = inst_pc;
        obs_req_valid  = imem_req_valid;
        obs_req_addr   = imem_req_addr;
        obs_count      = int'(dut.count);
        checkOutput("inst_valid", 64'(inst_valid), 64'(iq.size() != 0));
        checkOutput("inst", 64'(inst), 64'((iq.size() != 0) ? image(iq[0]) : NOP));
        checkOutput("inst_pc", inst_pc, (iq.size() != 0) ? iq[0] : 64'h0);
        checkOutput("req_valid", 64'(imem_req_valid), 64'(exp_rv));
        if (exp_rv) begin
            checkOutput("req_addr", imem_req_addr, fetch_pc_m);
        end
        checkOutput("count", 64'(dut.count), 64'(iq.size()));
        checkOutput("outstanding", 64'(dut.outstanding), 64'(inflight.size()));
        checkOutput("credit", 64'((int'(dut.count) + int'(dut.outstanding)) <= DEPTH), 64'd1);
        @(posedge clk);
        do_pop = (iq.size() != 0) && !stl && !redir;
        if (rsp) begin
            r = inflight.pop_front();
        end
        if (redir) begin
            iq.delete();
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            fetch_pc_m = tgt & ~64'h3;
        end else begin
            if (do_pop) begin
                void'(iq.pop_front());
            end
            if (rsp && !r.stale) begin
                iq.push_back(r.addr);
            end
            if (exp_rv && rdy) begin
                lat = $urandom_range(lat_max, lat_min);
                inflight.push_back('{fetch_pc_m, cyc + lat, 1'b0});
                fetch_pc_m += 64'd4;
            end
        end
        cyc++;
    endtask

    // Assert reset between clock edges and confirm outputs drop at once.
    task automatic doReset();
        @(negedge clk);
        reset          = 1'b1;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        stall          = 1'b0;
        #1;
        checkOutput("rst_inst_valid", 64'(inst_valid), 64'd0);
        checkOutput("rst_inst", 64'(inst), 64'(NOP));
        checkOutput("rst_inst_pc", inst_pc, 64'h0);
        checkOutput("rst_req_valid", 64'(imem_req_valid), 64'd0);
        iq.delete();
        inflight.delete();
        fetch_pc_m = 64'h0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        int n;

        $display("[TB] reset release, 1-cycle memory");
        doReset();
        lat_min = 1;
        lat_max = 1;
        applyStimulus(1, 0, 0, 0);
        checkOutput("first_req_addr", obs_req_addr, 64'h0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("lat_not_early", 64'(obs_inst_valid), 64'd0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("lat_first_valid", 64'(obs_inst_valid), 64'd1);
        checkOutput("lat_first_pc", obs_inst_pc, 64'h0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("stream_pc1", obs_inst_pc, 64'h4);
        applyStimulus(1, 0, 0, 0);
        checkOutput("stream_pc2", obs_inst_pc, 64'h8);

        $display("[TB] stall backpressure");
        repeat (6) applyStimulus(1, 1, 0, 0);
        checkOutput("stall_count_full", 64'(obs_count), 64'(DEPTH));
        checkOutput("stall_no_req", 64'(obs_req_valid), 64'd0);
        repeat (8) applyStimulus(1, 0, 0, 0);

        $display("[TB] redirect with two requests in flight, 3-cycle memory");
        doReset();
        lat_min = 3;
        lat_max = 3;
        n = 0;
        while (inflight.size() != 2 && n < 20) begin
            applyStimulus(1, 0, 0, 0);
            n++;
        end
        checkOutput("redir_setup", 64'(inflight.size()), 64'd2);
        applyStimulus(1, 0, 1, 64'h40);
        n = 0;
        do begin
            applyStimulus(1, 0, 0, 0);
            n++;
        end while (!obs_inst_valid && n < 30);
        checkOutput("redir_first_valid", 64'(obs_inst_valid), 64'd1);
        checkOutput("redir_first_pc", obs_inst_pc, 64'h40);
        repeat (6) applyStimulus(1, 0, 0, 0);

        $display("[TB] redirect and stall together, queue holding 3");
        doReset();
        lat_min = 1;
        lat_max = 1;
        n = 0;
        while (iq.size() != 3 && n < 20) begin
            applyStimulus(1, 1, 0, 0);
            n++;
        end
        checkOutput("rs_setup", 64'(iq.size()), 64'd3);
        applyStimulus(1, 1, 1, 64'h46);
        applyStimulus(1, 0, 0, 0);
        checkOutput("rs_inst_valid", 64'(obs_inst_valid), 64'd0);
        checkOutput("rs_count", 64'(obs_count), 64'd0);
        checkOutput("rs_req_valid", 64'(obs_req_valid), 64'd1);
        checkOutput("rs_req_addr", obs_req_addr, 64'h44);
        repeat (6) applyStimulus(1, 0, 0, 0);

        $display("[TB] random ready, latency 1..3, stalls and redirects");
        lat_min = 1;
        lat_max = 3;
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(1, 0)), ($urandom_range(3, 0) == 0),
                          ($urandom_range(39, 0) == 0), 64'($urandom_range(16'hFFFF, 0)));
        end

        $display("[TB] async reset with responses in flight");
        n = 0;
        while (inflight.size() == 0 && n < 20) begin
            applyStimulus(1, 0, 0, 0);
            n++;
        end
        checkOutput("mid_rst_inflight", 64'(inflight.size() != 0), 64'd1);
        doReset();
        lat_min = 1;
        lat_max = 1;
        applyStimulus(1, 0, 0, 0);
        checkOutput("restart_req_valid", 64'(obs_req_valid), 64'd1);
        checkOutput("restart_addr", obs_req_addr, 64'h0);
        repeat (10) applyStimulus(1, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
